dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_starve_ctr.sv | 33 +++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage
// and the debug port.
package dmem_arbiter_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } owner_e;

    localparam logic [2:0] DBG_FUNC3_WORD = 3'b010;
    localparam int         STARVE_W       = 4;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of cycles a debug request has waited; raises force_req on the
// cycle whose closing edge brings the count to STARVE_MAX.
module arb_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_req
);

    localparam logic [STARVE_W-1:0] FORCE_AT = STARVE_W'(STARVE_MAX - 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                waiting;

    assign waiting   = dbg_req & ~dbg_gnt;
    assign force_req = waiting & (starve_cnt == FORCE_AT);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!waiting) begin
            starve_cnt <= '0;
        end else if (starve_cnt != {STARVE_W{1'b1}}) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, debug accesses fill idle cycles or are forced
// in after STARVE_MAX waiting cycles. Define DMEM_ARB_PERF_EN to add perf counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_func3,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_cpu_cnt,
    output logic [31:0]           perf_dbg_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    arb_state_e state;
    arb_state_e state_next;
    owner_e     owner;
    logic       cpu_act;
    logic       force_req;

    assign cpu_act = cpu_rd | cpu_wr;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .dbg_req  (dbg_req),
        .dbg_gnt  (dbg_gnt),
        .force_req(force_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // FORCE lasts exactly one cycle and lets a starved debug request pre-empt the CPU.
    always_comb begin
        state_next = state;
        owner      = CPU;
        case (state)
            NORMAL: begin
                if (dbg_req && !cpu_act) owner = DBG;
                if (force_req) state_next = FORCE;
            end
            FORCE: begin
                if (dbg_req) owner = DBG;
                state_next = NORMAL;
            end
            default: state_next = NORMAL;
        endcase
    end

    assign dbg_gnt   = (owner == DBG) & dbg_req;
    assign cpu_stall = cpu_act & (owner == DBG);
    assign cpu_rdata = (owner == CPU) ? mem_rdata : '0;

    always_comb begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_func3 = cpu_func3;
        if (owner == DBG) begin
            mem_rd    = ~dbg_we;
            mem_wr    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_func3 = DBG_FUNC3_WORD;
        end
    end

    // Read data is captured at the granted edge; dbg_rdata holds until the next debug read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cpu_cnt   <= '0;
            perf_dbg_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (cpu_act && owner == CPU) perf_cpu_cnt <= perf_cpu_cnt + 32'd1;
            if (dbg_gnt) perf_dbg_cnt <= perf_dbg_cnt + 32'd1;
            if (cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural word memory
// (combinational read, posedge write). Perf checks run when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DM_ADDRESS    = 9;
    localparam int DATA_W        = 32;
    localparam int TB_STARVE_MAX = 4;

    logic                  clk;
    logic                  reset;
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [DM_ADDRESS-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [2:0]            cpu_func3;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_stall;
    logic                  dbg_req;
    logic                  dbg_we;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_W-1:0]     dbg_rdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_func3;
    logic [DATA_W-1:0]     mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]           perf_cpu_cnt;
    logic [31:0]           perf_dbg_cnt;
    logic [31:0]           perf_stall_cnt;
`endif

    logic [DATA_W-1:0] mem [0:127];
    int errors;
    int checks;

    dmem_arbiter #(
        .DM_ADDRESS(DM_ADDRESS),
        .DATA_W    (DATA_W),
        .STARVE_MAX(TB_STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_func3 (cpu_func3),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_func3 (mem_func3),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_cpu_cnt  (perf_cpu_cnt),
        .perf_dbg_cnt  (perf_dbg_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic apply_cpu(input logic rd, input logic wr, input logic [8:0] addr,
                             input logic [31:0] wdata, input logic [2:0] func3);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_func3 = func3;
    endtask

    task automatic apply_dbg(input logic req, input logic we, input logic [8:0] addr,
                             input logic [31:0] wdata);
        dbg_req   = req;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        apply_cpu(1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        tick;
        tick;
        reset = 1'b0;
        settle;
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %h required 0", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h required 0", dbg_rdata); end
        checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt: got %h required 0", dbg_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %h required 0", cpu_stall); end
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("[TB] FAIL rst_memrw: got %b required 00", {mem_rd, mem_wr}); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_cpu_rdata: got %h required 0", cpu_rdata); end
        checks++; if (dut.state !== NORMAL) begin errors++; $display("[TB] FAIL rst_state: got %0d required NORMAL", dut.state); end
        checks++; if (dut.u_starve.starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rst_starve: got %0d required 0", dut.u_starve.starve_cnt); end
    endtask

    task automatic test_cpu_passthrough;
        apply_cpu(1'b1, 1'b1, 9'h07C, 32'hCAFEF00D, 3'b001);
        settle;
        checks++; if ({mem_rd, mem_wr} !== 2'b11) begin errors++; $display("[TB] FAIL pass_memrw: got %b required 11", {mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 9'h07C) begin errors++; $display("[TB] FAIL pass_addr: got %h required 07c", mem_addr); end
        checks++; if (mem_wdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL pass_wdata: got %h required cafef00d", mem_wdata); end
        checks++; if (mem_func3 !== 3'b001) begin errors++; $display("[TB] FAIL pass_func3: got %b required 001", mem_func3); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall: got %h required 0", cpu_stall); end
        tick;
        apply_cpu(1'b0, 1'b0, 9'h010, 32'h0, 3'b101);
        settle;
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("[TB] FAIL idle_memrw: got %b required 00", {mem_rd, mem_wr}); end
        checks++; if (mem_func3 !== 3'b101) begin errors++; $display("[TB] FAIL idle_func3: got %b required 101", mem_func3); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL idle_cpu_rdata: got %h required deadbeef", cpu_rdata); end
        tick;
    endtask

    task automatic test_dbg_read;
        apply_dbg(1'b1, 1'b0, 9'h010, 32'h0);
        settle;
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt: got %h required 1", dbg_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rd_stall: got %h required 0", cpu_stall); end
        checks++; if ({mem_rd, mem_wr} !== 2'b10) begin errors++; $display("[TB] FAIL rd_memrw: got %b required 10", {mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 9'h010) begin errors++; $display("[TB] FAIL rd_addr: got %h required 010", mem_addr); end
        checks++; if (mem_func3 !== 3'b010) begin errors++; $display("[TB] FAIL rd_func3: got %b required 010", mem_func3); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_cpu_rdata: got %h required 0", cpu_rdata); end
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_rvalid: got %h required 0", dbg_rvalid); end
        tick;
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        settle;
        checks++; if (dbg_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_rvalid: got %h required 1", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata: got %h required deadbeef", dbg_rdata); end
        tick;
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rvalid_pulse: got %h required 0", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata_hold: got %h required deadbeef", dbg_rdata); end
    endtask

    task automatic test_dbg_write_cpu_read;
        apply_dbg(1'b1, 1'b1, 9'h020, 32'h12345678);
        settle;
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt: got %h required 1", dbg_gnt); end
        checks++; if ({mem_rd, mem_wr} !== 2'b01) begin errors++; $display("[TB] FAIL wr_memrw: got %b required 01", {mem_rd, mem_wr}); end
        tick;
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        apply_cpu(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        settle;
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_rvalid: got %h required 0", dbg_rvalid); end
        checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL wr_cpu_lw: got %h required 12345678", cpu_rdata); end
        tick;
        apply_cpu(1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    endtask

    task automatic test_starvation;
        logic exp_gnt;
        apply_dbg(1'b1, 1'b1, 9'h044, 32'h11112222);
        for (int i = 1; i <= TB_STARVE_MAX + 1; i++) begin
            apply_cpu(1'b0, 1'b1, 9'h040, 32'hC0DE0000 + 32'(i), 3'b010);
            settle;
            exp_gnt = (i == TB_STARVE_MAX + 1);
            checks++; if (dbg_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL starve_gnt_c%0d: got %h required %h", i, dbg_gnt, exp_gnt); end
            checks++; if (cpu_stall !== exp_gnt) begin errors++; $display("[TB] FAIL starve_stall_c%0d: got %h required %h", i, cpu_stall, exp_gnt); end
            tick;
        end
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        apply_cpu(1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        settle;
        checks++; if (mem[7'h10] !== 32'hC0DE0004) begin errors++; $display("[TB] FAIL starve_cpu_store: got %h required c0de0004", mem[7'h10]); end
        checks++; if (mem[7'h11] !== 32'h11112222) begin errors++; $display("[TB] FAIL starve_dbg_store: got %h required 11112222", mem[7'h11]); end
        checks++; if (dut.state !== NORMAL) begin errors++; $display("[TB] FAIL starve_state: got %0d required NORMAL", dut.state); end
        checks++; if (dut.u_starve.starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL starve_cnt_clr: got %0d required 0", dut.u_starve.starve_cnt); end
        tick;
    endtask

    task automatic test_abort;
        apply_cpu(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
        apply_dbg(1'b1, 1'b1, 9'h030, 32'h55AA55AA);
        for (int i = 1; i <= 2; i++) begin
            settle;
            checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("[TB] FAIL abort_gnt_c%0d: got %h required 0", i, dbg_gnt); end
            checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL abort_cpu_rdata_c%0d: got %h required deadbeef", i, cpu_rdata); end
            tick;
        end
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        tick;
        apply_cpu(1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        settle;
        checks++; if (dut.u_starve.starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL abort_starve: got %0d required 0", dut.u_starve.starve_cnt); end
        checks++; if (mem[7'h0C] !== 32'h0) begin errors++; $display("[TB] FAIL abort_nowrite: got %h required 0", mem[7'h0C]); end
        checks++; if (dut.state !== NORMAL) begin errors++; $display("[TB] FAIL abort_state: got %0d required NORMAL", dut.state); end
        tick;
    endtask

    task automatic test_back_to_back;
        apply_dbg(1'b1, 1'b0, 9'h010, 32'h0);
        settle;
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt1: got %h required 1", dbg_gnt); end
        tick;
        apply_dbg(1'b1, 1'b0, 9'h020, 32'h0);
        settle;
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt2: got %h required 1", dbg_gnt); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL b2b_rdata1: got %h required deadbeef", dbg_rdata); end
        tick;
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        settle;
        checks++; if (dbg_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rvalid2: got %h required 1", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL b2b_rdata2: got %h required 12345678", dbg_rdata); end
        tick;
    endtask

    task automatic test_reset_read;
        apply_dbg(1'b1, 1'b0, 9'h010, 32'h0);
        reset = 1'b1;
        settle;
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rstrd_gnt: got %h required 1", dbg_gnt); end
        tick;
        reset = 1'b0;
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        settle;
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstrd_rvalid: got %h required 0", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstrd_rdata: got %h required 0", dbg_rdata); end
        checks++; if (dut.state !== NORMAL) begin errors++; $display("[TB] FAIL rstrd_state: got %0d required NORMAL", dut.state); end
        tick;
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstrd_rvalid_late: got %h required 0", dbg_rvalid); end
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        apply_dbg(1'b1, 1'b1, 9'h054, 32'h0BADF00D);
        for (int i = 1; i <= TB_STARVE_MAX + 1; i++) begin
            apply_cpu(1'b0, 1'b1, 9'h050, 32'(i), 3'b010);
            tick;
        end
        apply_dbg(1'b0, 1'b0, 9'h000, 32'h0);
        apply_cpu(1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        settle;
        checks++; if (perf_cpu_cnt !== 32'(TB_STARVE_MAX)) begin errors++; $display("[TB] FAIL perf_cpu: got %0d required %0d", perf_cpu_cnt, TB_STARVE_MAX); end
        checks++; if (perf_dbg_cnt !== 32'd1) begin errors++; $display("[TB] FAIL perf_dbg: got %0d required 1", perf_dbg_cnt); end
        checks++; if (perf_stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL perf_stall: got %0d required 1", perf_stall_cnt); end
        tick;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[7'h04] = 32'hDEADBEEF;
        test_reset;
        test_cpu_passthrough;
        test_dbg_read;
        test_dbg_write_cpu_read;
        test_starvation;
        test_abort;
        test_back_to_back;
        test_reset_read;
`ifdef DMEM_ARB_PERF_EN
        test_perf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
